// File: rtl/ram_pkg.sv
// Shared types and defaults for the simple-dual-port RAM block.
package ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 12;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

    // CLEAR sweeps zeros through the array after reset, RUN is normal service.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_array.sv
// Plain storage: one write port and one registered read port, no reset,
// so that synthesis maps it onto block RAM.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; returns the pre-write value on a same-address collision.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dual_port_ram.sv
// Simple-dual-port RAM with post-reset zero-fill, write-first collision
// bypass, and a 1- or 2-cycle read pipeline with a valid strobe.
module dual_port_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  ready
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("dual_port_ram: READ_LATENCY must be 1 or 2");
    end

    ram_state_e            state;
    ram_state_e            state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  ready_q;
    logic                  clearing;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  collide;

    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_waddr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;

    logic                  v1;
    logic                  has1;
    logic                  byp1;
    logic [DATA_WIDTH-1:0] byp_data1;
    logic [DATA_WIDTH-1:0] stage1_data;

    assign clearing  = (state == CLEAR);
    assign wr_accept = write && ready_q;
    assign rd_accept = read && ready_q;
    assign collide   = rd_accept && wr_accept && (rd_address == wr_address);
    assign ready     = ready_q;

    // The clear sweep owns the write port until the last location is zeroed.
    assign arr_we    = clearing || wr_accept;
    assign arr_waddr = clearing ? clr_cnt : wr_address;
    assign arr_wdata = clearing ? '0 : data_in;

    // Leave CLEAR on the edge that zeroes the final location.
    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == '1) begin
            state_next = RUN;
        end
    end

    // State, sweep counter and ready flag; ready tracks the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) begin
                state <= CLEAR;
            end else begin
                state <= RUN;
            end
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == RUN);
            if (clearing) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    ram_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .wr_addr(arr_waddr),
        .wr_data(arr_wdata),
        .re     (rd_accept),
        .rd_addr(rd_address),
        .rd_data(arr_rdata)
    );

    // First read stage: remember whether the array result must be replaced by
    // the same-edge write data, and whether any read has landed since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            has1      <= 1'b0;
            byp1      <= 1'b0;
            byp_data1 <= '0;
        end else begin
            v1 <= rd_accept;
            if (rd_accept) begin
                has1 <= 1'b1;
                byp1 <= collide;
                if (collide) begin
                    byp_data1 <= data_in;
                end
            end
        end
    end

    assign stage1_data = !has1 ? '0 : (byp1 ? byp_data1 : arr_rdata);

    if (READ_LATENCY == 1) begin : g_lat1
        assign data_out = stage1_data;
        assign rd_valid = v1;
    end else begin : g_lat2
        logic                  v2;
        logic [DATA_WIDTH-1:0] data2;

        // Second read stage: capture the resolved first-stage value, hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2    <= 1'b0;
                data2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    data2 <= stage1_data;
                end
            end
        end

        assign data_out = data2;
        assign rd_valid = v2;
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench: a latency-1 and a latency-2 instance share one stimulus stream.
module tb_dual_port_ram;

    logic        clk;
    logic        rst_n;
    logic [63:0] data_in;
    logic [11:0] wr_address;
    logic        write;
    logic [11:0] rd_address;
    logic        read;

    logic [63:0] data_out1;
    logic        rd_valid1;
    logic        ready1;
    logic [63:0] data_out2;
    logic        rd_valid2;
    logic        ready2;

    int check_count = 0;
    int error_count = 0;

    dual_port_ram #(
        .DATA_WIDTH(64), .ADDR_WIDTH(12), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_address(wr_address),
        .write(write), .rd_address(rd_address), .read(read),
        .data_out(data_out1), .rd_valid(rd_valid1), .ready(ready1)
    );

    dual_port_ram #(
        .DATA_WIDTH(64), .ADDR_WIDTH(12), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_address(wr_address),
        .write(write), .rd_address(rd_address), .read(read),
        .data_out(data_out2), .rd_valid(rd_valid2), .ready(ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic wr, input logic [11:0] wa, input logic [63:0] wd,
                                  input logic rd, input logic [11:0] ra);
        write      = wr;
        wr_address = wa;
        data_in    = wd;
        read       = rd;
        rd_address = ra;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access edge, then check the latency-1 result and the latency-2 result a cycle later.
    task automatic do_access(input string tag, input logic wr, input logic [11:0] wa,
                             input logic [63:0] wd, input logic [11:0] ra,
                             input logic [63:0] expected);
        apply_stimulus(wr, wa, wd, 1'b1, ra);
        step();
        apply_stimulus(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
        check_output({tag, "_v1"}, 64'(rd_valid1), 64'd1);
        check_output({tag, "_d1"}, data_out1, expected);
        check_output({tag, "_v2_early"}, 64'(rd_valid2), 64'd0);
        step();
        check_output({tag, "_v2"}, 64'(rd_valid2), 64'd1);
        check_output({tag, "_d2"}, data_out2, expected);
        check_output({tag, "_v1_end"}, 64'(rd_valid1), 64'd0);
    endtask

    // Count edges from release until both instances report ready, with a bound.
    task automatic wait_ready(input string tag, input logic poke_during_clear);
        int  rise1;
        int  rise2;
        logic saw_valid;
        rise1 = 0;
        rise2 = 0;
        saw_valid = 1'b0;
        for (int e = 1; e <= 5000 && (rise1 == 0 || rise2 == 0); e++) begin
            step();
            if (ready1 && rise1 == 0) rise1 = e;
            if (ready2 && rise2 == 0) rise2 = e;
            if (rd_valid1 || rd_valid2) saw_valid = 1'b1;
            if (poke_during_clear && e == 30) begin
                apply_stimulus(1'b1, 12'h010, 64'h55, 1'b1, 12'h010);
            end else begin
                apply_stimulus(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
            end
        end
        check_output({tag, "_rise1"}, 64'(rise1), 64'd4096);
        check_output({tag, "_rise2"}, 64'(rise2), 64'd4096);
        check_output({tag, "_no_valid_in_clear"}, 64'(saw_valid), 64'd0);
    endtask

    initial begin
        logic saw;
        rst_n = 1'b0;
        apply_stimulus(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
        step();
        step();
        check_output("rst_ready1", 64'(ready1), 64'd0);
        check_output("rst_ready2", 64'(ready2), 64'd0);
        check_output("rst_valid1", 64'(rd_valid1), 64'd0);
        check_output("rst_valid2", 64'(rd_valid2), 64'd0);
        check_output("rst_data1", data_out1, 64'd0);
        check_output("rst_data2", data_out2, 64'd0);

        rst_n = 1'b1;
        wait_ready("clear", 1'b1);

        do_access("rd000", 1'b0, 12'h0, 64'h0, 12'h000, 64'h0);
        do_access("rd7ff", 1'b0, 12'h0, 64'h0, 12'h7FF, 64'h0);
        do_access("rdfff", 1'b0, 12'h0, 64'h0, 12'hFFF, 64'h0);

        apply_stimulus(1'b1, 12'h0A5, 64'h0123_4567_89AB_CDEF, 1'b0, 12'h0);
        step();
        do_access("rd0a5", 1'b0, 12'h0, 64'h0, 12'h0A5, 64'h0123_4567_89AB_CDEF);

        do_access("clear_drop", 1'b0, 12'h0, 64'h0, 12'h010, 64'h0);

        do_access("collide", 1'b1, 12'h3C0, 64'hDEAD_BEEF_0000_0001, 12'h3C0,
                  64'hDEAD_BEEF_0000_0001);

        // Write to the same address while a latency-2 read is in flight.
        apply_stimulus(1'b0, 12'h0, 64'h0, 1'b1, 12'h0A5);
        step();
        apply_stimulus(1'b1, 12'h0A5, 64'hFFFF_0000_FFFF_0000, 1'b0, 12'h0);
        check_output("inflight_d1", data_out1, 64'h0123_4567_89AB_CDEF);
        step();
        apply_stimulus(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
        check_output("inflight_v2", 64'(rd_valid2), 64'd1);
        check_output("inflight_d2", data_out2, 64'h0123_4567_89AB_CDEF);
        step();

        do_access("indep", 1'b1, 12'h0A6, 64'h1111_2222_3333_4444, 12'h0A5,
                  64'hFFFF_0000_FFFF_0000);
        do_access("rd0a6", 1'b0, 12'h0, 64'h0, 12'h0A6, 64'h1111_2222_3333_4444);

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 12'(i), 64'(i), 1'b0, 12'h0);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 12'h0, 64'h0, 1'b1, 12'(i));
            step();
            check_output($sformatf("burst_v1_%0d", i), 64'(rd_valid1), 64'd1);
            check_output($sformatf("burst_d1_%0d", i), data_out1, 64'(i));
            if (i > 0) begin
                check_output($sformatf("burst_v2_%0d", i - 1), 64'(rd_valid2), 64'd1);
                check_output($sformatf("burst_d2_%0d", i - 1), data_out2, 64'(i - 1));
            end
        end
        apply_stimulus(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
        step();
        check_output("burst_v1_end", 64'(rd_valid1), 64'd0);
        check_output("burst_hold1", data_out1, 64'd15);
        check_output("burst_v2_15", 64'(rd_valid2), 64'd1);
        check_output("burst_d2_15", data_out2, 64'd15);
        step();
        check_output("burst_hold2", data_out2, 64'd15);
        check_output("burst_v2_end", 64'(rd_valid2), 64'd0);

        // Reset one cycle after a read accept kills the pending latency-2 result.
        apply_stimulus(1'b0, 12'h0, 64'h0, 1'b1, 12'h0A6);
        step();
        apply_stimulus(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_v1", 64'(rd_valid1), 64'd0);
        check_output("midrst_v2", 64'(rd_valid2), 64'd0);
        check_output("midrst_d1", data_out1, 64'd0);
        check_output("midrst_d2", data_out2, 64'd0);
        check_output("midrst_ready", 64'(ready1), 64'd0);
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rd_valid2 || rd_valid1) saw = 1'b1;
        end
        check_output("midrst_no_pulse", 64'(saw), 64'd0);
        rst_n = 1'b1;
        wait_ready("reclear", 1'b0);
        do_access("reclear_0a6", 1'b0, 12'h0, 64'h0, 12'h0A6, 64'h0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
